// File: rtl/screen_pkg.sv
// Shared types for the VGA screen/game-flow controller and the screen drawers.
//  game_state_t : game-flow states held by screen_sequencer.
//  screen_sel_e : which drawer owns the VGA RGB output.
//  state_to_sel : screen shown for a given game state.
//  pend_prio    : rank of a pending transition; higher ranks may overwrite lower ones.
package screen_pkg;

  typedef enum logic [2:0] {
    StTitle,
    StPlay,
    StRespawn,
    StWin,
    StLose
  } game_state_t;

  typedef enum logic [1:0] {
    SelTitle = 2'd0,
    SelGame  = 2'd1,
    SelWin   = 2'd2,
    SelLose  = 2'd3
  } screen_sel_e;

  function automatic screen_sel_e state_to_sel(game_state_t s);
    screen_sel_e sel;
    case (s)
      StPlay, StRespawn: sel = SelGame;
      StWin:             sel = SelWin;
      StLose:            sel = SelLose;
      default:           sel = SelTitle;
    endcase
    return sel;
  endfunction

  function automatic logic [1:0] pend_prio(game_state_t s);
    logic [1:0] p;
    case (s)
      StWin:     p = 2'd3;
      StLose:    p = 2'd2;
      StRespawn: p = 2'd1;
      default:   p = 2'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector with one register stage.
//  clk_i  : clock
//  rst_ni : asynchronous active-low reset
//  sig_i  : level input (already synchronous to clk_i)
//  rise_o : high for the cycle in which sig_i is high and was low on the previous cycle
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_d, prev_q;

  always_comb begin
    prev_d = sig_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/screen_sequencer.sv
// Game-flow controller for the VGA path: TITLE -> PLAY -> (RESPAWN) -> WIN/LOSE -> TITLE.
// Tracks lives, gates the game logic and grants the RGB output to one screen drawer.
// Screen changes are held in a one-entry pending slot and commit only on a frame boundary.
//  vga_clock, reset          : pixel clock, asynchronous active-low reset
//  row, column               : scan position including blanking
//  display_enable            : visible-area flag
//  jump_button               : button level (synchronised)
//  mario_won, mario_died     : level-complete / death pulses from game logic
//  title/game/win/lose_rgb   : {r,g,b} from each drawer
//  game_reset_n, game_run    : reset and run-enable for game logic
//  screen_sel                : committed screen (0 title, 1 game, 2 win, 3 lose)
//  vga_red/green/blue        : registered pixel
//  leds                      : [2:0] lives, [6:3] one-hot screen, [9:7] zero
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH     = 640,
  parameter int unsigned SCREEN_HEIGHT    = 480,
  parameter int unsigned START_LIVES      = 3,
  parameter int unsigned RESPAWN_FRAMES   = 60,
  parameter int unsigned WIN_HOLD_FRAMES  = 180,
  parameter int unsigned LOSE_HOLD_FRAMES = 120
) (
  input  logic                                  vga_clock,
  input  logic                                  reset,
  // Scan coordinates span the visible width plus 160 columns of horizontal blanking.
  input  logic [$clog2(SCREEN_WIDTH + 160)-1:0] row,
  input  logic [$clog2(SCREEN_WIDTH + 160)-1:0] column,
  input  logic                                  display_enable,
  input  logic                                  jump_button,
  input  logic                                  mario_won,
  input  logic                                  mario_died,
  input  logic [11:0]                           title_rgb,
  input  logic [11:0]                           game_rgb,
  input  logic [11:0]                           win_rgb,
  input  logic [11:0]                           lose_rgb,
  output logic                                  game_reset_n,
  output logic                                  game_run,
  output logic [1:0]                            screen_sel,
  output logic [3:0]                            vga_red,
  output logic [3:0]                            vga_green,
  output logic [3:0]                            vga_blue,
  output logic [9:0]                            leds
);

  localparam int unsigned CoordW     = $clog2(SCREEN_WIDTH + 160);
  localparam logic [2:0]  StartLives = 3'(START_LIVES);
  localparam logic [7:0]  RespLast   = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0]  WinHold    = 8'(WIN_HOLD_FRAMES);
  localparam logic [7:0]  LoseHold   = 8'(LOSE_HOLD_FRAMES);

  logic jump_press, won_edge, died_edge;

  edge_detect u_jump_edge (
    .clk_i  (vga_clock),
    .rst_ni (reset),
    .sig_i  (jump_button),
    .rise_o (jump_press)
  );

  edge_detect u_won_edge (
    .clk_i  (vga_clock),
    .rst_ni (reset),
    .sig_i  (mario_won),
    .rise_o (won_edge)
  );

  edge_detect u_died_edge (
    .clk_i  (vga_clock),
    .rst_ni (reset),
    .sig_i  (mario_died),
    .rise_o (died_edge)
  );

  game_state_t state_d, state_q, pend_state_d, pend_state_q, event_state;
  screen_sel_e screen_sel_d, screen_sel_q;
  logic [2:0]  lives_d, lives_q;
  logic [7:0]  frame_cnt_d, frame_cnt_q, cnt_limit;
  logic        pend_valid_d, pend_valid_q, event_valid, start_game;
  logic        frame_tick_d, frame_tick_q;
  logic        game_reset_n_d, game_reset_n_q, game_run_d, game_run_q;
  logic [11:0] rgb_d, rgb_q;

  always_comb begin
    frame_tick_d   = (row == CoordW'(SCREEN_HEIGHT)) && (column == '0);
    state_d        = state_q;
    lives_d        = lives_q;
    frame_cnt_d    = frame_cnt_q;
    pend_valid_d   = pend_valid_q;
    pend_state_d   = pend_state_q;
    event_valid    = 1'b0;
    event_state    = StTitle;
    start_game     = 1'b0;

    if (state_q == StWin) begin
      cnt_limit = WinHold;
    end else if (state_q == StLose) begin
      cnt_limit = LoseHold;
    end else begin
      cnt_limit = 8'hFF;
    end

    // Frame boundary: commit the pending screen, else run the respawn timer / frame counter.
    if (frame_tick_q) begin
      if (pend_valid_q) begin
        state_d      = pend_state_q;
        frame_cnt_d  = '0;
        pend_valid_d = 1'b0;
        if (state_q == StTitle && pend_state_q == StPlay) begin
          start_game = 1'b1;
          lives_d    = StartLives;
        end
      end else if (state_q == StRespawn && frame_cnt_q == RespLast) begin
        state_d     = StPlay;
        frame_cnt_d = '0;
      end else if (frame_cnt_q != cnt_limit) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end

    // Events are judged against the committed state; lives change immediately.
    case (state_q)
      StTitle: begin
        if (jump_press) begin
          event_valid = 1'b1;
          event_state = StPlay;
        end
      end
      StPlay: begin
        if (won_edge) begin
          event_valid = 1'b1;
          event_state = StWin;
        end else if (died_edge) begin
          event_valid = 1'b1;
          event_state = (lives_q <= 3'd1) ? StLose : StRespawn;
          if (lives_q != 3'd0) begin
            lives_d = lives_q - 3'd1;
          end
        end
      end
      StWin: begin
        if (jump_press && frame_cnt_q == WinHold) begin
          event_valid = 1'b1;
          event_state = StTitle;
        end
      end
      StLose: begin
        if (jump_press && frame_cnt_q == LoseHold) begin
          event_valid = 1'b1;
          event_state = StTitle;
        end
      end
      default: ;
    endcase

    // Compared against the post-commit slot so an event on a commit cycle waits a full frame.
    if (event_valid && (!pend_valid_d || pend_prio(event_state) > pend_prio(pend_state_d))) begin
      pend_valid_d = 1'b1;
      pend_state_d = event_state;
    end

    screen_sel_d   = state_to_sel(state_d);
    game_run_d     = (state_d == StPlay);
    game_reset_n_d = !(start_game || (state_d == StRespawn && frame_cnt_d == '0));
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StTitle;
      pend_state_q   <= StTitle;
      pend_valid_q   <= 1'b0;
      screen_sel_q   <= SelTitle;
      lives_q        <= StartLives;
      frame_cnt_q    <= '0;
      frame_tick_q   <= 1'b0;
      game_reset_n_q <= 1'b0;
      game_run_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_state_q   <= pend_state_d;
      pend_valid_q   <= pend_valid_d;
      screen_sel_q   <= screen_sel_d;
      lives_q        <= lives_d;
      frame_cnt_q    <= frame_cnt_d;
      frame_tick_q   <= frame_tick_d;
      game_reset_n_q <= game_reset_n_d;
      game_run_q     <= game_run_d;
    end
  end

  always_comb begin
    rgb_d = '0;
    if (display_enable && state_q != StRespawn) begin
      case (screen_sel_q)
        SelTitle: rgb_d = title_rgb;
        SelGame:  rgb_d = game_rgb;
        SelWin:   rgb_d = win_rgb;
        default:  rgb_d = lose_rgb;
      endcase
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign vga_red      = rgb_q[11:8];
  assign vga_green    = rgb_q[7:4];
  assign vga_blue     = rgb_q[3:0];
  assign game_reset_n = game_reset_n_q;
  assign game_run     = game_run_q;
  assign screen_sel   = screen_sel_q;

  always_comb begin
    leds      = '0;
    leds[2:0] = lives_q;
    leds[6:3] = 4'b0001 << screen_sel_q;
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer. Frames are compressed: a frame boundary is a single
// cycle with row=480/column=0, so long hold counts stay cheap.
module tb_screen_sequencer;

  logic        vga_clock = 1'b0;
  logic        reset;
  logic [9:0]  row, column;
  logic        display_enable, jump_button, mario_won, mario_died;
  logic [11:0] title_rgb, game_rgb, win_rgb, lose_rgb;
  logic        game_reset_n, game_run;
  logic [1:0]  screen_sel;
  logic [3:0]  vga_red, vga_green, vga_blue;
  logic [9:0]  leds;

  screen_sequencer dut (
    .vga_clock      (vga_clock),
    .reset          (reset),
    .row            (row),
    .column         (column),
    .display_enable (display_enable),
    .jump_button    (jump_button),
    .mario_won      (mario_won),
    .mario_died     (mario_died),
    .title_rgb      (title_rgb),
    .game_rgb       (game_rgb),
    .win_rgb        (win_rgb),
    .lose_rgb       (lose_rgb),
    .game_reset_n   (game_reset_n),
    .game_run       (game_run),
    .screen_sel     (screen_sel),
    .vga_red        (vga_red),
    .vga_green      (vga_green),
    .vga_blue       (vga_blue),
    .leds           (leds)
  );

  always #5 vga_clock = ~vga_clock;

  typedef struct {
    logic        de;
    logic [11:0] t;
    logic [11:0] g;
    logic [11:0] w;
    logic [11:0] l;
    logic [11:0] exp;
  } vec_t;

  vec_t        tbl_title [4];
  vec_t        tbl_win   [3];
  logic [11:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clock);
    #1;
  endtask

  task automatic frame();
    row    = 10'd480;
    column = 10'd0;
    step();
    row    = 10'd100;
    column = 10'd5;
    step();
  endtask

  task automatic press_jump();
    jump_button = 1'b1;
    step();
    jump_button = 1'b0;
    step();
  endtask

  task automatic pulse_died();
    mario_died = 1'b1;
    step();
    mario_died = 1'b0;
    step();
  endtask

  // Drive one pixel vector; the expected pixel is queued now and compared one clock later.
  task automatic apply(input string name, input vec_t v);
    logic [11:0] exp;
    display_enable = v.de;
    title_rgb      = v.t;
    game_rgb       = v.g;
    win_rgb        = v.w;
    lose_rgb       = v.l;
    exp_q.push_back(v.exp);
    step();
    exp = exp_q.pop_front();
    check(name, int'({vga_red, vga_green, vga_blue}), int'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl_title[0] = '{de: 1'b0, t: 12'hFFF, g: 12'h111, w: 12'h222, l: 12'h333, exp: 12'h000};
    tbl_title[1] = '{de: 1'b1, t: 12'h123, g: 12'h111, w: 12'h222, l: 12'h333, exp: 12'h123};
    tbl_title[2] = '{de: 1'b1, t: 12'hA5C, g: 12'hFFF, w: 12'hFFF, l: 12'hFFF, exp: 12'hA5C};
    tbl_title[3] = '{de: 1'b0, t: 12'hA5C, g: 12'hFFF, w: 12'hFFF, l: 12'hFFF, exp: 12'h000};
    tbl_win[0]   = '{de: 1'b0, t: 12'h123, g: 12'h456, w: 12'hFFF, l: 12'h789, exp: 12'h000};
    tbl_win[1]   = '{de: 1'b1, t: 12'h123, g: 12'h456, w: 12'hFFF, l: 12'h789, exp: 12'hFFF};
    tbl_win[2]   = '{de: 1'b1, t: 12'hFFF, g: 12'hFFF, w: 12'h0A5, l: 12'hFFF, exp: 12'h0A5};

    reset = 1'b0;
    row = 10'd100;
    column = 10'd5;
    display_enable = 1'b0;
    jump_button = 1'b0;
    mario_won = 1'b0;
    mario_died = 1'b0;
    title_rgb = '0;
    game_rgb = '0;
    win_rgb = '0;
    lose_rgb = '0;
    step();
    step();
    check("reset_sel", int'(screen_sel), 0);
    check("reset_leds", int'(leds), 'h00B);
    check("reset_game_reset_n", int'(game_reset_n), 0);
    check("reset_game_run", int'(game_run), 0);
    check("reset_rgb", int'({vga_red, vga_green, vga_blue}), 0);
    reset = 1'b1;
    step();
    step();
    check("post_reset_game_reset_n", int'(game_reset_n), 1);

    for (int i = 0; i < 4; i++) apply("title_rgb_tbl", tbl_title[i]);

    // Press at row 100, held across several frames: one commit only, at the next frame edge.
    jump_button = 1'b1;
    step();
    step();
    step();
    check("title_no_early_commit", int'(screen_sel), 0);
    row = 10'd480;
    column = 10'd0;
    step();
    check("title_tick_registered", int'(screen_sel), 0);
    row = 10'd100;
    column = 10'd5;
    step();
    check("play_sel", int'(screen_sel), 1);
    check("play_game_reset_pulse", int'(game_reset_n), 0);
    check("play_run", int'(game_run), 1);
    check("play_leds", int'(leds), 'h013);
    step();
    check("play_game_reset_one_cycle", int'(game_reset_n), 1);
    for (int i = 0; i < 5; i++) frame();
    check("jump_held_sel", int'(screen_sel), 1);
    check("jump_held_run", int'(game_run), 1);
    jump_button = 1'b0;
    step();

    // Death landing on the frame_tick cycle pends until the following frame edge.
    row = 10'd480;
    column = 10'd0;
    step();
    row = 10'd100;
    column = 10'd5;
    mario_died = 1'b1;
    step();
    mario_died = 1'b0;
    check("death1_lives", int'(leds[2:0]), 2);
    check("death1_no_same_cycle_commit", int'(game_run), 1);
    step();
    frame();
    check("respawn_run", int'(game_run), 0);
    check("respawn_game_reset", int'(game_reset_n), 0);
    check("respawn_sel", int'(screen_sel), 1);
    apply("respawn_black", '{de: 1'b1, t: 12'h111, g: 12'hABC, w: 12'h222, l: 12'h333,
                             exp: 12'h000});
    frame();
    check("respawn_reset_release", int'(game_reset_n), 1);
    repeat (58) frame();
    check("respawn_59_frames", int'(game_run), 0);
    frame();
    check("respawn_60_frames", int'(game_run), 1);
    apply("play_game_rgb", '{de: 1'b1, t: 12'h111, g: 12'h5A3, w: 12'h222, l: 12'h333,
                             exp: 12'h5A3});

    pulse_died();
    check("death2_lives", int'(leds[2:0]), 1);
    frame();
    check("death2_respawn", int'(game_run), 0);
    repeat (60) frame();
    check("death2_resume", int'(game_run), 1);
    pulse_died();
    check("death3_lives", int'(leds[2:0]), 0);
    frame();
    check("lose_sel", int'(screen_sel), 3);
    check("lose_leds", int'(leds), 'h040);
    check("lose_run", int'(game_run), 0);
    apply("lose_rgb", '{de: 1'b1, t: 12'h111, g: 12'h222, w: 12'h333, l: 12'h777,
                        exp: 12'h777});

    repeat (119) frame();
    press_jump();
    frame();
    check("lose_jump_before_hold", int'(screen_sel), 3);
    press_jump();
    check("lose_jump_waits_frame", int'(screen_sel), 3);
    frame();
    check("lose_to_title", int'(leds), 'h008);

    press_jump();
    frame();
    check("restart_lives", int'(leds), 'h013);
    step();
    pulse_died();
    frame();
    repeat (60) frame();
    check("restart_lives2", int'(leds[2:0]), 2);

    // Won and died together: win takes priority and no life is lost.
    mario_won = 1'b1;
    mario_died = 1'b1;
    step();
    mario_won = 1'b0;
    mario_died = 1'b0;
    step();
    check("won_died_lives", int'(leds[2:0]), 2);
    frame();
    check("win_sel", int'(screen_sel), 2);
    check("win_leds", int'(leds), 'h022);
    for (int i = 0; i < 3; i++) apply("win_rgb_tbl", tbl_win[i]);
    repeat (100) frame();
    press_jump();
    frame();
    check("win_jump_frame100", int'(screen_sel), 2);
    repeat (79) frame();
    press_jump();
    frame();
    check("win_to_title", int'(screen_sel), 0);

    // Asynchronous reset mid-frame from PLAY with a death pending.
    press_jump();
    frame();
    step();
    display_enable = 1'b1;
    game_rgb = 12'hFFF;
    pulse_died();
    check("pre_reset_rgb", int'({vga_red, vga_green, vga_blue}), 'hFFF);
    @(posedge vga_clock);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_rgb", int'({vga_red, vga_green, vga_blue}), 0);
    check("async_reset_sel", int'(screen_sel), 0);
    check("async_reset_leds", int'(leds), 'h00B);
    check("async_reset_run", int'(game_run), 0);
    check("async_reset_game_reset_n", int'(game_reset_n), 0);
    step();
    reset = 1'b1;
    step();
    frame();
    frame();
    check("after_reset_stays_title", int'(screen_sel), 0);
    check("after_reset_not_running", int'(game_run), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
